// File: rtl/nvdla_dbb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// nvdla_dbb_arbiter_pkg
//   Shared types and constants for the DBB client arbiter.
//   - state_dbb_arb_t : arbiter transaction FSM states
//   - NVDLA_PRIMARY_MEMIF_WIDTH : default beat data width of the DBB port
//   - onehot_idx()    : index of the set bit of a one-hot vector (up to 8)
// ----------------------------------------------------------------------------
package nvdla_dbb_arbiter_pkg;

    localparam int NVDLA_PRIMARY_MEMIF_WIDTH = 512;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WDATA,
        ARB_WRESP,
        ARB_RDATA
    } state_dbb_arb_t;

    // Grants never exceed 8 clients, so a fixed 8-bit scan is enough.
    function automatic int onehot_idx(input logic [7:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/nvdla_dbb_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// nvdla_dbb_rr_pick
//   Combinational round-robin picker. Returns the first requester at or
//   after ptr_i, wrapping around, as a one-hot grant.
//   Ports:
//     req_i   in  N_REQ   request vector
//     ptr_i   in  PTR_W   highest-priority position
//     gnt_o   out N_REQ   one-hot grant (all zero when no request)
//     valid_o out 1       some request was found
// ----------------------------------------------------------------------------
module nvdla_dbb_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             valid_o
);

    int idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // Modulo keeps the scan in range for non-power-of-two N_REQ.
            idx = (int'(ptr_i) + i) % N_REQ;
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nvdla_dbb_arbiter.sv
// ----------------------------------------------------------------------------
// nvdla_dbb_arbiter
//   Shares one nvdla_hwpe2dbb bridge between N_REQ DBB clients. One
//   transaction is in flight at a time; clients are served round-robin per
//   transaction. Write data, write response and read data are steered
//   combinationally between the bridge and the granted client.
//
//   Handshakes: a transfer happens on a cycle where both valid and ready are
//   high; valid never depends on ready, and non-granted clients always see
//   valid=0 / ready=0.
//
//   Ports:
//     clk_i, rst_ni, clear_i         clock, async active-low reset, sync clear
//     req_*                          per-client request channel (N_REQ wide)
//     w_*                            per-client write data channel
//     b_valid_o/b_ready_i, b_id_o    per-client write response, shared id
//     r_valid_o/r_ready_i, r_*_o     per-client read data, shared payload
//     m_req_*, m_w_*, m_b_*, m_r_*   single channel set toward the bridge
//     busy_o                         transaction in flight
//     gnt_o                          one-hot current grant
//     err_o                          sticky write beat count error
//     dbg_state_o                    FSM state for observation
// ----------------------------------------------------------------------------
module nvdla_dbb_arbiter
    import nvdla_dbb_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 8,
    parameter int DATA_W = NVDLA_PRIMARY_MEMIF_WIDTH,
    parameter int STRB_W = DATA_W / 8,
    parameter int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    // client request channel
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ-1:0]          req_write_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*LEN_W-1:0]    req_len_i,
    input  logic [N_REQ*ID_W-1:0]     req_id_i,
    // client write data
    input  logic [N_REQ-1:0]          w_valid_i,
    output logic [N_REQ-1:0]          w_ready_o,
    input  logic [N_REQ*DATA_W-1:0]   w_data_i,
    input  logic [N_REQ*STRB_W-1:0]   w_strb_i,
    input  logic [N_REQ-1:0]          w_last_i,
    // client write response
    output logic [N_REQ-1:0]          b_valid_o,
    input  logic [N_REQ-1:0]          b_ready_i,
    output logic [ID_W-1:0]           b_id_o,
    // client read data
    output logic [N_REQ-1:0]          r_valid_o,
    input  logic [N_REQ-1:0]          r_ready_i,
    output logic [DATA_W-1:0]         r_data_o,
    output logic                      r_last_o,
    output logic [ID_W-1:0]           r_id_o,
    // bridge request channel
    output logic                      m_req_valid_o,
    input  logic                      m_req_ready_i,
    output logic                      m_req_write_o,
    output logic [ADDR_W-1:0]         m_req_addr_o,
    output logic [LEN_W-1:0]          m_req_len_o,
    output logic [ID_W-1:0]           m_req_id_o,
    // bridge write data
    output logic                      m_w_valid_o,
    input  logic                      m_w_ready_i,
    output logic [DATA_W-1:0]         m_w_data_o,
    output logic [STRB_W-1:0]         m_w_strb_o,
    output logic                      m_w_last_o,
    // bridge write response
    input  logic                      m_b_valid_i,
    output logic                      m_b_ready_o,
    // bridge read data
    input  logic                      m_r_valid_i,
    output logic                      m_r_ready_o,
    input  logic [DATA_W-1:0]         m_r_data_i,
    input  logic                      m_r_last_i,
    // status
    output logic                      busy_o,
    output logic [N_REQ-1:0]          gnt_o,
    output logic                      err_o,
    output state_dbb_arb_t            dbg_state_o
);

    localparam int CNT_W = LEN_W + 1;

    state_dbb_arb_t   state_q,    state_d;
    logic [N_REQ-1:0] gnt_q,      gnt_d;
    logic [PTR_W-1:0] idx_q,      idx_d;
    logic [PTR_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic             write_q,    write_d;
    logic [LEN_W-1:0] len_q,      len_d;
    logic [ID_W-1:0]  id_q,       id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             err_q,      err_d;

    logic [N_REQ-1:0] pick_gnt;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [CNT_W-1:0] len_ext;
    logic [CNT_W-1:0] cnt_inc;
    logic [PTR_W-1:0] next_ptr;

    nvdla_dbb_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = PTR_W'(onehot_idx(8'(pick_gnt)));
        // A zero length field encodes the maximum burst (2**LEN_W beats).
        len_ext  = (len_q == '0) ? (CNT_W'(1) << LEN_W) : {1'b0, len_q};
        cnt_inc  = beat_cnt_q + CNT_W'(1);
        next_ptr = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        write_d    = write_q;
        len_d      = len_q;
        id_d       = id_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        req_ready_o   = '0;
        w_ready_o     = '0;
        b_valid_o     = '0;
        b_id_o        = '0;
        r_valid_o     = '0;
        r_data_o      = '0;
        r_last_o      = 1'b0;
        r_id_o        = '0;
        m_req_valid_o = 1'b0;
        m_req_write_o = 1'b0;
        m_req_addr_o  = '0;
        m_req_len_o   = '0;
        m_req_id_o    = '0;
        m_w_valid_o   = 1'b0;
        m_w_data_o    = '0;
        m_w_strb_o    = '0;
        m_w_last_o    = 1'b0;
        m_b_ready_o   = 1'b0;
        m_r_ready_o   = 1'b0;

        if (clear_i) begin
            // Abandon everything; all handshake outputs stay at their zero defaults.
            state_d    = ARB_IDLE;
            gnt_d      = '0;
            idx_d      = '0;
            rr_ptr_d   = '0;
            write_d    = 1'b0;
            len_d      = '0;
            id_d       = '0;
            beat_cnt_d = '0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    // Only arbitrate here; the request handshake happens in ISSUE.
                    if (pick_valid) begin
                        gnt_d   = pick_gnt;
                        idx_d   = pick_idx;
                        write_d = req_write_i[pick_idx];
                        len_d   = req_len_i[int'(pick_idx)*LEN_W +: LEN_W];
                        id_d    = req_id_i[int'(pick_idx)*ID_W +: ID_W];
                        state_d = ARB_ISSUE;
                    end
                end

                ARB_ISSUE: begin
                    // Address is taken live from the client, which holds it until accepted.
                    m_req_valid_o       = 1'b1;
                    m_req_write_o       = write_q;
                    m_req_addr_o        = req_addr_i[int'(idx_q)*ADDR_W +: ADDR_W];
                    m_req_len_o         = len_q;
                    m_req_id_o          = id_q;
                    req_ready_o[idx_q]  = m_req_ready_i;
                    if (m_req_ready_i) begin
                        beat_cnt_d = '0;
                        state_d    = write_q ? ARB_WDATA : ARB_RDATA;
                    end
                end

                ARB_WDATA: begin
                    m_w_valid_o      = w_valid_i[idx_q];
                    m_w_data_o       = w_data_i[int'(idx_q)*DATA_W +: DATA_W];
                    m_w_strb_o       = w_strb_i[int'(idx_q)*STRB_W +: STRB_W];
                    m_w_last_o       = w_last_i[idx_q];
                    w_ready_o[idx_q] = m_w_ready_i;
                    if (w_valid_i[idx_q] && m_w_ready_i) begin
                        beat_cnt_d = cnt_inc;
                        if (w_last_i[idx_q]) begin
                            if (cnt_inc != len_ext) err_d = 1'b1;
                            state_d = ARB_WRESP;
                        end else if (cnt_inc == len_ext) begin
                            // Final beat without last: flag it but keep waiting for last.
                            err_d = 1'b1;
                        end
                    end
                end

                ARB_WRESP: begin
                    b_valid_o[idx_q] = m_b_valid_i;
                    m_b_ready_o      = b_ready_i[idx_q];
                    b_id_o           = id_q;
                    if (m_b_valid_i && b_ready_i[idx_q]) begin
                        rr_ptr_d = next_ptr;
                        gnt_d    = '0;
                        state_d  = ARB_IDLE;
                    end
                end

                ARB_RDATA: begin
                    r_valid_o[idx_q] = m_r_valid_i;
                    m_r_ready_o      = r_ready_i[idx_q];
                    r_data_o         = m_r_data_i;
                    r_last_o         = m_r_last_i;
                    r_id_o           = id_q;
                    if (m_r_valid_i && r_ready_i[idx_q] && m_r_last_i) begin
                        rr_ptr_d = next_ptr;
                        gnt_d    = '0;
                        state_d  = ARB_IDLE;
                    end
                end

                default: begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            write_q    <= 1'b0;
            len_q      <= '0;
            id_q       <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            write_q    <= write_d;
            len_q      <= len_d;
            id_q       <= id_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign busy_o      = (state_q != ARB_IDLE);
    assign gnt_o       = gnt_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nvdla_dbb_arbiter.sv
module tb_nvdla_dbb_arbiter;
  import nvdla_dbb_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int IW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  logic clear_i;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]    req_valid_i, req_ready_o, req_write_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*LW-1:0] req_len_i;
  logic [N*IW-1:0] req_id_i;
  logic [N-1:0]    w_valid_i, w_ready_o, w_last_i;
  logic [N*DW-1:0] w_data_i;
  logic [N*SW-1:0] w_strb_i;
  logic [N-1:0]    b_valid_o, b_ready_i;
  logic [IW-1:0]   b_id_o;
  logic [N-1:0]    r_valid_o, r_ready_i;
  logic [DW-1:0]   r_data_o;
  logic            r_last_o;
  logic [IW-1:0]   r_id_o;
  logic            m_req_valid_o, m_req_ready_i, m_req_write_o;
  logic [AW-1:0]   m_req_addr_o;
  logic [LW-1:0]   m_req_len_o;
  logic [IW-1:0]   m_req_id_o;
  logic            m_w_valid_o, m_w_ready_i, m_w_last_o;
  logic [DW-1:0]   m_w_data_o;
  logic [SW-1:0]   m_w_strb_o;
  logic            m_b_valid_i, m_b_ready_o;
  logic            m_r_valid_i, m_r_ready_o, m_r_last_i;
  logic [DW-1:0]   m_r_data_i;
  logic            busy_o, err_o;
  logic [N-1:0]    gnt_o;
  state_dbb_arb_t  dbg_state_o;

  nvdla_dbb_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .LEN_W(LW), .ID_W(IW), .DATA_W(DW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_id_i(req_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .r_last_o(r_last_o), .r_id_o(r_id_o),
    .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i),
    .m_req_write_o(m_req_write_o), .m_req_addr_o(m_req_addr_o),
    .m_req_len_o(m_req_len_o), .m_req_id_o(m_req_id_o),
    .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i), .m_w_data_o(m_w_data_o),
    .m_w_strb_o(m_w_strb_o), .m_w_last_o(m_w_last_o),
    .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o),
    .m_r_data_i(m_r_data_i), .m_r_last_i(m_r_last_i),
    .busy_o(busy_o), .gnt_o(gnt_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    req_valid_i = '0; req_write_i = '0; req_addr_i = '0; req_len_i = '0; req_id_i = '0;
    w_valid_i = '0; w_data_i = '0; w_strb_i = '0; w_last_i = '0;
    b_ready_i = '0; r_ready_i = '0;
    m_req_ready_i = 1'b0; m_w_ready_i = 1'b0; m_b_valid_i = 1'b0;
    m_r_valid_i = 1'b0; m_r_data_i = '0; m_r_last_i = 1'b0;
  endtask

  task automatic start_req(input int c, input bit wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic [IW-1:0] id);
    req_valid_i[c]          = 1'b1;
    req_write_i[c]          = wr;
    req_addr_i[c*AW +: AW]  = addr;
    req_len_i[c*LW +: LW]   = len;
    req_id_i[c*IW +: IW]    = id;
  endtask

  // Called in IDLE with the request already driven; hold = cycles the bridge stalls.
  task automatic issue(input int c, input bit wr, input logic [AW-1:0] addr,
                       input logic [LW-1:0] len, input logic [IW-1:0] id,
                       input int hold, input bit keep);
    step();
    check("issue_state", dbg_state_o, ARB_ISSUE);
    check("issue_gnt", gnt_o, 64'(1 << c));
    check("issue_busy", busy_o, 1);
    for (int k = 0; k <= hold; k++) begin
      check("m_req_valid", m_req_valid_o, 1);
      check("m_req_write", m_req_write_o, wr);
      check("m_req_addr", m_req_addr_o, addr);
      check("m_req_len", m_req_len_o, len);
      check("m_req_id", m_req_id_o, id);
      check("req_ready_stall", req_ready_o, 0);
      if (k < hold) step();
    end
    m_req_ready_i = 1'b1;
    #1;
    check("req_ready", req_ready_o, 64'(1 << c));
    step();
    m_req_ready_i = 1'b0;
    if (!keep) req_valid_i[c] = 1'b0;
    check("post_issue_state", dbg_state_o, wr ? ARB_WDATA : ARB_RDATA);
  endtask

  task automatic write_beats(input int c, input int n, input int last_at);
    logic [DW-1:0] d;
    for (int b = 1; b <= n; b++) begin
      d = 32'hD000_0000 + 32'(c << 12) + 32'(b);
      exp_q.push_back(d);
      w_valid_i[c]          = 1'b1;
      w_data_i[c*DW +: DW]  = d;
      w_strb_i[c*SW +: SW]  = 4'hF;
      w_last_i[c]           = (b == last_at);
      m_w_ready_i           = 1'b1;
      #1;
      check("m_w_valid", m_w_valid_o, 1);
      check("m_w_data", m_w_data_o, exp_q.pop_front());
      check("m_w_strb", m_w_strb_o, 4'hF);
      check("m_w_last", m_w_last_o, (b == last_at));
      check("w_ready", w_ready_o, 64'(1 << c));
      step();
    end
    w_valid_i[c] = 1'b0;
    w_last_i[c]  = 1'b0;
    m_w_ready_i  = 1'b0;
  endtask

  task automatic wresp(input int c, input logic [IW-1:0] id);
    check("wresp_state", dbg_state_o, ARB_WRESP);
    b_ready_i[c] = 1'b1;
    #1;
    check("b_valid_before_bridge", b_valid_o, 0);
    m_b_valid_i = 1'b1;
    #1;
    check("b_valid", b_valid_o, 64'(1 << c));
    check("b_id", b_id_o, id);
    check("m_b_ready", m_b_ready_o, 1);
    step();
    m_b_valid_i  = 1'b0;
    b_ready_i[c] = 1'b0;
    check("wresp_done_busy", busy_o, 0);
    check("wresp_done_gnt", gnt_o, 0);
  endtask

  task automatic read_beats(input int c, input int n, input logic [IW-1:0] id);
    for (int b = 1; b <= n; b++) begin
      m_r_valid_i  = 1'b1;
      m_r_data_i   = 32'hBEEF_0000 + 32'(b);
      m_r_last_i   = (b == n);
      r_ready_i[c] = 1'b1;
      #1;
      check("r_valid", r_valid_o, 64'(1 << c));
      check("r_data", r_data_o, 32'hBEEF_0000 + 32'(b));
      check("r_last", r_last_o, (b == n));
      check("r_id", r_id_o, id);
      check("m_r_ready", m_r_ready_o, 1);
      step();
    end
    m_r_valid_i  = 1'b0;
    m_r_last_i   = 1'b0;
    r_ready_i[c] = 1'b0;
    check("read_done_busy", busy_o, 0);
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 0);
    check({tag, "_w_ready"}, w_ready_o, 0);
    check({tag, "_b_valid"}, b_valid_o, 0);
    check({tag, "_r_valid"}, r_valid_o, 0);
    check({tag, "_r_data"}, r_data_o, 0);
    check({tag, "_m_req_valid"}, m_req_valid_o, 0);
    check({tag, "_m_w_valid"}, m_w_valid_o, 0);
    check({tag, "_m_b_ready"}, m_b_ready_o, 0);
    check({tag, "_m_r_ready"}, m_r_ready_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_gnt"}, gnt_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    step();
    step();
    check_all_quiet("reset");
    check("reset_state", dbg_state_o, ARB_IDLE);
    rst_ni = 1'b1;
    step();

    // 1: client0 write len=4, clean burst
    start_req(0, 1'b1, 32'h0000_1000, 8'd4, 8'h5A);
    #1;
    check("idle_no_m_req", m_req_valid_o, 0);
    check("idle_no_req_ready", req_ready_o, 0);
    issue(0, 1'b1, 32'h0000_1000, 8'd4, 8'h5A, 0, 1'b0);
    write_beats(0, 4, 4);
    wresp(0, 8'h5A);
    check("t1_err", err_o, 0);

    // clear returns rr_ptr to 0
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;

    // 2: both clients read len=2 together; client0 first
    start_req(0, 1'b0, 32'h0000_2000, 8'd2, 8'h11);
    start_req(1, 1'b0, 32'h0000_3000, 8'd2, 8'h22);
    issue(0, 1'b0, 32'h0000_2000, 8'd2, 8'h11, 0, 1'b0);
    read_beats(0, 2, 8'h11);
    check("t2_gap_m_req_valid", m_req_valid_o, 0);
    issue(1, 1'b0, 32'h0000_3000, 8'd2, 8'h22, 0, 1'b0);
    read_beats(1, 2, 8'h22);

    // 3: client1 keeps requesting, client0 arrives once -> 1,0,1
    start_req(1, 1'b0, 32'h0000_4000, 8'd1, 8'h31);
    issue(1, 1'b0, 32'h0000_4000, 8'd1, 8'h31, 0, 1'b1);
    start_req(0, 1'b0, 32'h0000_5000, 8'd1, 8'h30);
    read_beats(1, 1, 8'h31);
    issue(0, 1'b0, 32'h0000_5000, 8'd1, 8'h30, 0, 1'b0);
    read_beats(0, 1, 8'h30);
    issue(1, 1'b0, 32'h0000_4000, 8'd1, 8'h31, 0, 1'b0);
    read_beats(1, 1, 8'h31);

    // 4: write len=3 with last on beat 2 -> sticky err, then clear
    start_req(0, 1'b1, 32'h0000_6000, 8'd3, 8'h44);
    issue(0, 1'b1, 32'h0000_6000, 8'd3, 8'h44, 0, 1'b0);
    write_beats(0, 2, 2);
    check("t4_err_set", err_o, 1);
    wresp(0, 8'h44);
    check("t4_err_sticky", err_o, 1);
    check("t4_idle", dbg_state_o, ARB_IDLE);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("t4_err_cleared", err_o, 0);

    // len=0 means 256 beats
    start_req(1, 1'b1, 32'h0000_7000, 8'd0, 8'h45);
    issue(1, 1'b1, 32'h0000_7000, 8'd0, 8'h45, 0, 1'b0);
    write_beats(1, 256, 256);
    check("len0_err", err_o, 0);
    wresp(1, 8'h45);

    // len=1 beat without last -> err, still collecting data
    start_req(0, 1'b1, 32'h0000_7100, 8'd1, 8'h46);
    issue(0, 1'b1, 32'h0000_7100, 8'd1, 8'h46, 0, 1'b0);
    write_beats(0, 1, 0);
    check("nolast_err", err_o, 1);
    check("nolast_state", dbg_state_o, ARB_WDATA);
    write_beats(0, 1, 1);
    wresp(0, 8'h46);

    // 5: reset in RDATA beat 1 of 4 (rr_ptr is 1 here)
    start_req(1, 1'b0, 32'h0000_8000, 8'd4, 8'h55);
    issue(1, 1'b0, 32'h0000_8000, 8'd4, 8'h55, 0, 1'b0);
    m_r_valid_i  = 1'b1;
    m_r_data_i   = 32'h1234_5678;
    m_r_last_i   = 1'b0;
    r_ready_i[1] = 1'b1;
    step();
    #1;
    check("t5_r_valid_before", r_valid_o, 2'b10);
    rst_ni = 1'b0;
    #1;
    check_all_quiet("t5_in_reset");
    step();
    drive_idle();
    rst_ni = 1'b1;
    step();
    check("t5_state_after", dbg_state_o, ARB_IDLE);
    start_req(0, 1'b0, 32'h0000_9000, 8'd1, 8'h60);
    start_req(1, 1'b0, 32'h0000_9100, 8'd1, 8'h61);
    issue(0, 1'b0, 32'h0000_9000, 8'd1, 8'h60, 0, 1'b0);
    read_beats(0, 1, 8'h60);
    issue(1, 1'b0, 32'h0000_9100, 8'd1, 8'h61, 0, 1'b0);
    read_beats(1, 1, 8'h61);

    // 6: bridge stalls request accept for 10 cycles
    start_req(0, 1'b1, 32'h0000_A000, 8'd1, 8'h70);
    issue(0, 1'b1, 32'h0000_A000, 8'd1, 8'h70, 10, 1'b0);
    write_beats(0, 1, 1);
    wresp(0, 8'h70);
    check("t6_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
